toggle_decoder: RTL and testbench
=================================

// Module: toggle_decoder
// PURPOSE
//  Receive side of a toggle-encoded event link. The sender flips its T-output
//  once per event; this block recovers one pulse per flip in the clk domain.
//  - Synchronises the asynchronous toggle line.
//  - Rebuilds the sender's level and emits a 1-cycle pulse per detected flip.
//  - Queues pending events behind a valid/ready handshake for downstream logic.
// PARAMETERS
//  SYNC_STAGES    2  synchroniser depth on t_in, legal 2..4
//  CNT_W          4  pending-event counter width, max queued = 2**CNT_W-1
//  FILTER_CYCLES  3  qualification length, used only with TOGGLE_DEC_FILTER_EN, legal 1..15
// PORTS
//  clk       in   1      clock, rising edge
//  reset_n   in   1      reset, asynchronous assert, active-low
//  t_in      in   1      toggle line from sender, asynchronous to clk
//  level     out  1      recovered sender level (reconstructed Q)
//  pulse     out  1      high 1 cycle per accepted toggle
//  ev_valid  out  1      pending != 0
//  ev_ready  in   1      downstream consumes one event when ev_valid && ev_ready
//  pending   out  CNT_W  number of queued, unconsumed events
//  overflow  out  1      sticky: an event was dropped because pending was full
//  ovf_clr   in   1      synchronous clear of overflow
// BEHAVIOUR
//  - Reset (reset_n=0, async): sync chain, level, pulse, pending, overflow,
//    filter counter and FSM all go to 0/IDLE immediately. ev_valid=0.
//  - Sync: t_in passes through SYNC_STAGES flops. s = last flop output.
//  - Detect (no filter): at a rising edge with s != level:
//    - level <= s and pulse <= 1, both on the same edge.
//    - Otherwise pulse <= 0.
//  - Latency (no filter): t_in stable before edge E0.
//    - level and pulse change at edge E0+SYNC_STAGES.
//    - pulse drops at the next edge.
//  - Input contract: each t_in level held >= 2 clk cycles.
//    - Add FILTER_CYCLES when filtered.
//    - Shorter glitches may be lost or merged; never checked.
//  - Queue, updated on the same edge as pulse. Let inc=pulse_next, dec=ev_valid&&ev_ready:
//    - inc && !dec: if pending < max, pending+1. Else drop the event and set overflow.
//    - !inc && dec: pending-1.
//    - inc && dec: pending unchanged. No overflow, even when full.
//    - neither: hold.
//  - ev_valid is combinational from pending (pending != 0). No event is lost on
//    decrement-from-1 with a simultaneous inc.
//  - overflow: ovf_clr=1 clears it. A simultaneous new overflow wins (stays 1).
//  - Reset mid-operation: queue discarded. After release, level=0.
//    - If t_in=1 at release, exactly one event is detected after the normal latency.
//    - Accepted behaviour: the link re-aligns to the sender's level.
//  - pending never wraps. Max is 2**CNT_W-1 (15 at default).
// CONFIGURATION
//  TOGGLE_DEC_FILTER_EN defined:
//    - FSM states IDLE, QUAL. IDLE->QUAL when s != level; the qualification counter loads 1.
//    - QUAL: s == level -> back to IDLE, counter cleared. A glitch is ignored, no pulse.
//    - QUAL: s != level and count == FILTER_CYCLES -> accept:
//      level <= s, pulse <= 1, back to IDLE. Otherwise count+1.
//    - Added latency: FILTER_CYCLES edges over the unfiltered timing.
//  Not defined:
//    - No FSM or counter; FILTER_CYCLES ignored.
//    - A toggle is accepted on the first edge s != level.
// TESTING
//  1. Reset: reset_n=0 mid-cycle with pending=5 -> all outputs 0 at once, async.
//     Release with t_in=0 -> no pulse.
//  2. Single toggle: t_in 0->1, SYNC_STAGES=2, no filter.
//     -> pulse for 1 cycle at edge E0+2, level=1, pending=1, ev_valid=1.
//     ev_ready=1 one cycle -> pending=0.
//  3. Burst: 16 toggles every 4 cycles, ev_ready=0 -> pending saturates at 15.
//     16th event dropped, overflow=1. ovf_clr -> overflow=0, pending stays 15.
//  4. Simultaneous: pending=15, toggle accepted on the same edge as ev_ready=1
//     -> pending stays 15, overflow stays 0.
//     pending=1 with same pair -> pending stays 1, ev_valid stays 1.
//  5. Filter (macro on, FILTER_CYCLES=3): t_in high for 2 cycles then back -> no pulse.
//     t_in high steady -> pulse at E0+2+3, level=1.
//  6. Reset-realign: t_in=1 steady, pulse reset_n low then high
//     -> exactly one pulse after latency, pending=1.

Source files
------------

// File: rtl/toggle_decoder_if.sv
// Event handshake bundle for toggle_decoder: queued-event count plus valid/ready.
// The decoder drives the master side, downstream logic takes the slave side.
interface toggle_decoder_if #(
  parameter int CNT_W = 4
);
  logic             ev_valid;
  logic             ev_ready;
  logic [CNT_W-1:0] pending;

  modport master (output ev_valid, output pending, input ev_ready);
  modport slave  (input ev_valid, input pending, output ev_ready);
endinterface

// File: rtl/toggle_decoder.sv
// toggle_decoder: receive side of a toggle-encoded event link.
// Synchronises t_in, rebuilds the sender's level, emits one pulse per flip and
// counts pending events behind a valid/ready handshake (saturating, sticky overflow).
// Optional glitch qualification is enabled by defining TOGGLE_DEC_FILTER_EN.
module toggle_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 4,
  parameter int FILTER_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             t_in,
  output logic             level,
  output logic             pulse,
  output logic             overflow,
  input  logic             ovf_clr,
  toggle_decoder_if.master ev
);
  localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PEND_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  logic                   level_r;
  logic                   pulse_r;
  logic                   overflow_r;
  logic [CNT_W-1:0]       pending_r;
  logic                   level_next_s;
  logic                   pulse_next_s;
  logic [CNT_W-1:0]       pending_next_s;
  logic                   overflow_next_s;
  logic                   valid_s;
  logic                   inc_s;
  logic                   dec_s;
  logic                   drop_s;

  // Shift the asynchronous toggle line through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], t_in};
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

`ifdef TOGGLE_DEC_FILTER_EN
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_QUAL   = 1'b1;
  localparam logic [3:0] QCNT_LAST = 4'(FILTER_CYCLES);

  logic [0:0] state_r;
  logic [0:0] state_next_s;
  logic [3:0] qcnt_r;
  logic [3:0] qcnt_next_s;

  // Qualify a level change: it must persist FILTER_CYCLES edges before acceptance.
  always_comb begin
    state_next_s = state_r;
    qcnt_next_s  = qcnt_r;
    level_next_s = level_r;
    pulse_next_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (s_s != level_r) begin
          state_next_s = ST_QUAL;
          qcnt_next_s  = 4'd1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_QUAL: begin
        if (s_s == level_r) begin
          state_next_s = ST_IDLE;
          qcnt_next_s  = 4'd0;
        end else if (qcnt_r == QCNT_LAST) begin
          state_next_s = ST_IDLE;
          qcnt_next_s  = 4'd0;
          level_next_s = s_s;
          pulse_next_s = 1'b1;
        end else begin
          qcnt_next_s  = qcnt_r + 4'd1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        qcnt_next_s  = 4'd0;
      end
    endcase
  end

  // Register the qualification FSM and its counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      qcnt_r  <= 4'd0;
    end else begin
      state_r <= state_next_s;
      qcnt_r  <= qcnt_next_s;
    end
  end
`else
  // Accept a flip on the first edge where the synchronised line differs from level.
  always_comb begin
    level_next_s = s_s;
    pulse_next_s = (s_s != level_r);
  end
`endif

  assign valid_s = (pending_r != PEND_ZERO);
  assign inc_s   = pulse_next_s;
  assign dec_s   = valid_s && ev.ev_ready;
  assign drop_s  = inc_s && !dec_s && (pending_r == PEND_MAX);

  // Saturating pending counter and sticky overflow (a new drop beats ovf_clr).
  always_comb begin
    pending_next_s  = pending_r;
    overflow_next_s = overflow_r;
    if (inc_s && !dec_s) begin
      if (pending_r != PEND_MAX) begin
        pending_next_s = pending_r + PEND_ONE;
      end else begin
        pending_next_s = pending_r;
      end
    end else if (!inc_s && dec_s) begin
      pending_next_s = pending_r - PEND_ONE;
    end else begin
      pending_next_s = pending_r;
    end
    if (drop_s) begin
      overflow_next_s = 1'b1;
    end else if (ovf_clr) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = overflow_r;
    end
  end

  // Register recovered level, event pulse, queue depth and overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_r    <= 1'b0;
      pulse_r    <= 1'b0;
      pending_r  <= PEND_ZERO;
      overflow_r <= 1'b0;
    end else begin
      level_r    <= level_next_s;
      pulse_r    <= pulse_next_s;
      pending_r  <= pending_next_s;
      overflow_r <= overflow_next_s;
    end
  end

  assign level       = level_r;
  assign pulse       = pulse_r;
  assign overflow    = overflow_r;
  assign ev.ev_valid = valid_s;
  assign ev.pending  = pending_r;

endmodule

// File: tb/tb_toggle_decoder.sv
// Scoreboard bench for toggle_decoder. Stimulus pushes the expected pulse cycle
// of every sender flip; a negedge monitor pops it and keeps a queue model.
`timescale 1ns/1ps
module tb_toggle_decoder;
  localparam int SYNC_STAGES   = 2;
  localparam int CNT_W         = 4;
  localparam int FILTER_CYCLES = 3;
`ifdef TOGGLE_DEC_FILTER_EN
  localparam int FILT = FILTER_CYCLES;
`else
  localparam int FILT = 0;
`endif
  localparam int LAT      = SYNC_STAGES + FILT;
  localparam int HOLD_MIN = 2 + FILT;
  localparam int SP       = 4 + FILT;
  localparam int PMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic t_in = 1'b0;
  logic ovf_clr = 1'b0;
  logic level, pulse, overflow;

  toggle_decoder_if #(.CNT_W(CNT_W)) ev();

  toggle_decoder #(
    .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .FILTER_CYCLES(FILTER_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .t_in(t_in), .level(level), .pulse(pulse),
    .overflow(overflow), .ovf_clr(ovf_clr), .ev(ev)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  exp_q[$];
  int  m_pend = 0;
  bit  m_ovf = 1'b0;
  bit  m_level = 1'b0;
  bit  rdy_e = 1'b0;
  bit  clr_e = 1'b0;
  int  ready_pct = 50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Edge bookkeeping: cycle count and the handshake inputs seen by that edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rdy_e = ev.ev_ready;
      clr_e = ovf_clr;
    end
  end

  // Monitor: reference model of the event queue, compared every cycle.
  initial begin
    bit exp_p, dec, drop;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_pend = 0; m_ovf = 1'b0; m_level = 1'b0;
        exp_q.delete();
        exp_p = 1'b0;
      end else begin
        exp_p = (exp_q.size() > 0) && (exp_q[0] == cyc);
        if (exp_p) void'(exp_q.pop_front());
        dec  = (m_pend > 0) && rdy_e;
        drop = exp_p && !dec && (m_pend == PMAX);
        if (drop) m_ovf = 1'b1;
        else if (clr_e) m_ovf = 1'b0;
        if (exp_p && !dec && m_pend < PMAX) m_pend++;
        else if (!exp_p && dec) m_pend--;
        if (exp_p) m_level = ~m_level;
      end
      check("pulse", pulse, exp_p);
      check("level", level, m_level);
      check("pending", ev.pending, m_pend);
      check("ev_valid", ev.ev_valid, m_pend != 0);
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step(input int n, input bit rnd);
    repeat (n) begin
      tick();
      if (rnd) begin
        ev.ev_ready = ($urandom_range(99) < ready_pct);
        ovf_clr     = ($urandom_range(99) < 5);
      end
    end
  endtask

  // Sender flips its line; the matching pulse is due LAT edges after the next edge.
  task automatic toggle();
    t_in = ~t_in;
    exp_q.push_back(cyc + 1 + LAT);
  endtask

  initial begin
    logic lvl_save;
    ev.ev_ready = 1'b0;
    repeat (3) tick();
    check("rst_level", level, 1'b0);
    check("rst_pending", ev.pending, 0);
    check("rst_overflow", overflow, 1'b0);
    reset_n = 1'b1;
    step(2, 1'b0);

    // Single toggle then one consume.
    toggle();
    step(LAT + 1, 1'b0);
    check("single_pulse", pulse, 1'b1);
    check("single_level", level, 1'b1);
    check("single_pending", ev.pending, 1);
    ev.ev_ready = 1'b1;
    tick();
    ev.ev_ready = 1'b0;
    check("consume_pending", ev.pending, 0);
    check("consume_valid", ev.ev_valid, 1'b0);
    step(HOLD_MIN, 1'b0);

    // Burst of 16 with no consumer: saturate and overflow, then clear.
    for (int i = 0; i < 16; i++) begin
      toggle();
      step(SP, 1'b0);
    end
    step(LAT + 2, 1'b0);
    check("burst_pending", ev.pending, PMAX);
    check("burst_overflow", overflow, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_overflow", overflow, 1'b0);
    check("clr_pending", ev.pending, PMAX);

    // Full queue: accept and consume on the same edge.
    toggle();
    step(LAT, 1'b0);
    ev.ev_ready = 1'b1;
    tick();
    ev.ev_ready = 1'b0;
    check("full_pair_pulse", pulse, 1'b1);
    check("full_pair_pending", ev.pending, PMAX);
    check("full_pair_overflow", overflow, 1'b0);
    ev.ev_ready = 1'b1;
    repeat (PMAX - 1) tick();
    ev.ev_ready = 1'b0;
    check("drain_to_one", ev.pending, 1);
    toggle();
    step(LAT, 1'b0);
    ev.ev_ready = 1'b1;
    tick();
    ev.ev_ready = 1'b0;
    check("one_pair_pending", ev.pending, 1);
    check("one_pair_valid", ev.ev_valid, 1'b1);
    step(HOLD_MIN, 1'b0);

    // Async reset mid-cycle with pending=5, release with t_in=0.
    ev.ev_ready = 1'b1;
    step(20, 1'b0);
    ev.ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      toggle();
      step(SP, 1'b0);
    end
    step(LAT + 2, 1'b0);
    check("pre_reset_pending", ev.pending, 5);
    #1 reset_n = 1'b0;
    #1;
    check("async_pending", ev.pending, 0);
    check("async_valid", ev.ev_valid, 1'b0);
    check("async_level", level, 1'b0);
    check("async_pulse", pulse, 1'b0);
    check("async_overflow", overflow, 1'b0);
    tick();
    t_in = 1'b0;
    step(3, 1'b0);
    reset_n = 1'b1;
    step(LAT + 4, 1'b0);
    check("release_t0_pending", ev.pending, 0);

    // Reset with t_in=1 held: one realignment event after release.
    toggle();
    step(LAT + 3, 1'b0);
    reset_n = 1'b0;
    step(2, 1'b0);
    reset_n = 1'b1;
    exp_q.push_back(cyc + 1 + LAT);
    step(LAT + 3, 1'b0);
    check("realign_pending", ev.pending, 1);
    check("realign_level", level, 1'b1);

`ifdef TOGGLE_DEC_FILTER_EN
    // Two-cycle glitch must be rejected; a steady change accepted.
    lvl_save = level;
    t_in = ~t_in;
    step(2, 1'b0);
    t_in = ~t_in;
    step(HOLD_MIN + 4, 1'b0);
    check("glitch_level", level, lvl_save);
    toggle();
    step(LAT + 1, 1'b0);
    check("filter_pulse", pulse, 1'b1);
    step(HOLD_MIN, 1'b0);
`else
    lvl_save = 1'b0;
`endif

    // Randomised traffic with varying consumer throughput.
    for (int i = 0; i < 160; i++) begin
      if (i % 40 == 0) ready_pct = (i == 40) ? 5 : ((i == 80) ? 95 : 40);
      toggle();
      step($urandom_range(HOLD_MIN, HOLD_MIN + 5), 1'b1);
    end
    ev.ev_ready = 1'b0;
    ovf_clr = 1'b0;
    step(LAT + 3, 1'b0);
    check("no_missing_pulses", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
